// File: rtl/sa_wresp_pkg.sv
// Shared definitions for the write-response router: BRESP encodings and
// the helper that pulls the master index out of a slave-side transaction ID.
package sa_wresp_pkg;

  typedef enum logic [1:0] {
    BRESP_OKAY   = 2'b00,
    BRESP_EXOKAY = 2'b01,
    BRESP_SLVERR = 2'b10,
    BRESP_DECERR = 2'b11
  } bresp_e;

  // The master index occupies the top mst_id_w bits of a slv_id_w-wide ID.
  function automatic int mst_idx(input logic [63:0] id,
                                 input int          slv_id_w,
                                 input int          mst_id_w);
    logic [63:0] mask;
    mask = (64'd1 << mst_id_w) - 64'd1;
    return int'((id >> (slv_id_w - mst_id_w)) & mask);
  endfunction

endpackage

// File: rtl/sa_bresp_slice.sv
// One-entry valid/ready register slice carrying a single write response
// toward one master; accepts a new entry in the same cycle the old one leaves.
module sa_bresp_slice #(
  parameter int DATA_W = 9
) (
  input  logic              ACLK_i,
  input  logic              ARESETn_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              full_q;
  logic [DATA_W-1:0] data_q;

  assign in_ready  = !full_q || out_ready;
  assign out_valid = full_q;
  assign out_data  = data_q;

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) full_q <= 1'b0;
    else if (in_ready) full_q <= in_valid;
  end

  // NOTE: the payload register is deliberately not reset; it is only
  // observed while full_q is set, which the reset does clear.
  always_ff @(posedge ACLK_i) begin
    if (in_valid && in_ready) data_q <= in_data;
  end

endmodule

// File: rtl/sa_wresp_router.sv
// Routes slave write responses back to the issuing master by ID, tracks
// outstanding writes per master, and drops responses nobody is waiting for.
module sa_wresp_router
  import sa_wresp_pkg::*;
#(
  parameter int MST_AMT         = 3,
  parameter int OUTSTANDING_AMT = 8,
  parameter int MST_ID_W        = (MST_AMT > 1) ? $clog2(MST_AMT) : 1,
  parameter int TRANS_MST_ID_W  = 5,
  parameter int TRANS_SLV_ID_W  = TRANS_MST_ID_W + MST_ID_W,
  parameter int TRANS_WR_RESP_W = 2,
  parameter int OUT_REG         = 1
) (
  input  logic                                ACLK_i,
  input  logic                                ARESETn_i,
  input  logic [TRANS_SLV_ID_W-1:0]           s_BID_i,
  input  logic [TRANS_WR_RESP_W-1:0]          s_BRESP_i,
  input  logic                                s_BVALID_i,
  output logic                                s_BREADY_o,
  output logic [TRANS_SLV_ID_W*MST_AMT-1:0]   dsp_BID_o,
  output logic [TRANS_WR_RESP_W*MST_AMT-1:0]  dsp_BRESP_o,
  output logic [MST_AMT-1:0]                  dsp_BVALID_o,
  input  logic [MST_AMT-1:0]                  dsp_BREADY_i,
  input  logic [TRANS_SLV_ID_W-1:0]           AW_AxID_i,
  input  logic                                AW_shift_en_i,
  output logic [MST_AMT-1:0]                  AW_stall_o,
  output logic                                unexp_resp_o
);

  localparam int               CNT_W   = $clog2(OUTSTANDING_AMT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OUTSTANDING_AMT);
  localparam int               LANE_W  = TRANS_SLV_ID_W + TRANS_WR_RESP_W;

  logic [CNT_W-1:0]   cnt_q [MST_AMT];
  logic [MST_AMT-1:0] b_sel, aw_sel, lane_ready, inc, dec;
  logic               b_legal, b_ready, b_hs, unexp_q;
  int                 b_mst, aw_mst;

  always_comb begin
    b_mst  = mst_idx(64'(s_BID_i), TRANS_SLV_ID_W, MST_ID_W);
    aw_mst = mst_idx(64'(AW_AxID_i), TRANS_SLV_ID_W, MST_ID_W);
    b_sel  = '0;
    aw_sel = '0;
    for (int m = 0; m < MST_AMT; m++) begin
      b_sel[m]  = (b_mst == m);
      aw_sel[m] = (aw_mst == m);
    end
  end

  // An index beyond MST_AMT never matches a lane, so it falls out as illegal.
  always_comb begin
    b_legal = 1'b0;
    b_ready = 1'b1;
    for (int m = 0; m < MST_AMT; m++) begin
      if (b_sel[m] && (cnt_q[m] != '0)) begin
        b_legal = 1'b1;
        b_ready = lane_ready[m];
      end
    end
  end

  assign s_BREADY_o   = ARESETn_i & b_ready;
  assign b_hs         = s_BVALID_i & s_BREADY_o;
  assign unexp_resp_o = unexp_q;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int m = 0; m < MST_AMT; m++) begin
      inc[m] = AW_shift_en_i & aw_sel[m] & ~AW_stall_o[m];
      dec[m] = b_hs & b_legal & b_sel[m];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      for (int m = 0; m < MST_AMT; m++) cnt_q[m] <= '0;
      unexp_q <= 1'b0;
    end else begin
      for (int m = 0; m < MST_AMT; m++) begin
        if (inc[m] && !dec[m])      cnt_q[m] <= cnt_q[m] + CNT_W'(1);
        else if (dec[m] && !inc[m]) cnt_q[m] <= cnt_q[m] - CNT_W'(1);
      end
      unexp_q <= b_hs & ~b_legal;
    end
  end

  for (genvar m = 0; m < MST_AMT; m++) begin : g_lane
    logic              lane_valid;
    logic [LANE_W-1:0] lane_data;

    assign lane_valid = s_BVALID_i & b_legal & b_sel[m];
    assign AW_stall_o[m] = (cnt_q[m] == CNT_MAX);
    assign dsp_BID_o[(m+1)*TRANS_SLV_ID_W-1 -: TRANS_SLV_ID_W]    = lane_data[LANE_W-1 -: TRANS_SLV_ID_W];
    assign dsp_BRESP_o[(m+1)*TRANS_WR_RESP_W-1 -: TRANS_WR_RESP_W] = lane_data[TRANS_WR_RESP_W-1:0];

    if (OUT_REG != 0) begin : g_reg
      sa_bresp_slice #(.DATA_W(LANE_W)) u_slice (
        .ACLK_i    (ACLK_i),
        .ARESETn_i (ARESETn_i),
        .in_valid  (lane_valid),
        .in_ready  (lane_ready[m]),
        .in_data   ({s_BID_i, s_BRESP_i}),
        .out_valid (dsp_BVALID_o[m]),
        .out_ready (dsp_BREADY_i[m]),
        .out_data  (lane_data)
      );
    end else begin : g_pass
      assign lane_ready[m]   = dsp_BREADY_i[m];
      assign dsp_BVALID_o[m] = lane_valid & ARESETn_i;
      assign lane_data       = {s_BID_i, s_BRESP_i};
    end
  end

endmodule
